// File: rtl/proc_controller_pkg.sv
// Shared types and constants for the six-instruction processor control unit.
package proc_pkg;

    localparam int IR_W   = 16;
    localparam int D_AW   = 8;
    localparam int RF_AW  = 4;
    localparam int ALU_SW = 3;
    localparam int ST_W   = 4;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [ALU_SW-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_SW-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_SW-1:0] ALU_SUB  = 3'b010;

    // Instruction field positions: opcode[15:12], A[11:8], B[7:4], W[3:0].
    localparam int OP_LSB    = 12;
    localparam int RA_LSB    = 8;
    localparam int RB_LSB    = 4;
    localparam int RW_LSB    = 0;
    localparam int LD_AD_LSB = 4;
    localparam int ST_AD_LSB = 0;

    function automatic logic [3:0] ir_opcode(input logic [IR_W-1:0] ir);
        return ir[OP_LSB +: 4];
    endfunction

    function automatic logic [RF_AW-1:0] ir_field(input logic [IR_W-1:0] ir, input int lsb);
        return ir[lsb +: RF_AW];
    endfunction

    function automatic logic [D_AW-1:0] ir_daddr(input logic [IR_W-1:0] ir, input int lsb);
        return ir[lsb +: D_AW];
    endfunction

endpackage

// File: rtl/proc_controller_if.sv
// Controller <-> datapath bundle: instruction word in, fetch/decode/execute controls out.
interface proc_controller_if;
    import proc_pkg::*;

    logic [IR_W-1:0]   IR;
    logic              PC_clr;
    logic              PC_up;
    logic              IM_re;
    logic              IR_Id;
    logic [D_AW-1:0]   D_addr;
    logic              D_wr;
    logic              RF_s;
    logic [RF_AW-1:0]  RF_W_addr;
    logic              RF_W_en;
    logic [RF_AW-1:0]  RF_Ra_addr;
    logic [RF_AW-1:0]  RF_Rb_addr;
    logic [ALU_SW-1:0] ALU_s0;
    logic              Halted;
    logic [ST_W-1:0]   State;

    modport master (
        input  IR,
        output PC_clr, PC_up, IM_re, IR_Id, D_addr, D_wr, RF_s, RF_W_addr,
               RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, State
    );

    modport slave (
        output IR,
        input  PC_clr, PC_up, IM_re, IR_Id, D_addr, D_wr, RF_s, RF_W_addr,
               RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted, State
    );

endinterface

// File: rtl/proc_controller.sv
// Moore FSM sequencing fetch/decode/execute; strobes decode from the state register
// so an asynchronous reset drops any pending write immediately.
module proc_controller
    import proc_pkg::*;
(
    input  logic             Clk,
    input  logic             ResetN,
    proc_controller_if.master bus
);

    state_t state_r;
    state_t next_state_s;

    // State register with asynchronous abort to INIT.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_r <= S_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; NOOP and illegal opcodes go straight back to FETCH.
    always_comb begin
        next_state_s = S_INIT;
        case (state_r)
            S_INIT:   next_state_s = S_FETCH;
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: begin
                case (ir_opcode(bus.IR))
                    OP_STORE: next_state_s = S_STORE;
                    OP_LOAD:  next_state_s = S_LOAD_A;
                    OP_ADD:   next_state_s = S_ADD;
                    OP_SUB:   next_state_s = S_SUB;
                    OP_HALT:  next_state_s = S_HALT;
                    default:  next_state_s = S_FETCH;
                endcase
            end
            S_LOAD_A: next_state_s = S_LOAD_B;
            S_LOAD_B: next_state_s = S_FETCH;
            S_STORE:  next_state_s = S_FETCH;
            S_ADD:    next_state_s = S_FETCH;
            S_SUB:    next_state_s = S_FETCH;
            S_HALT:   next_state_s = S_HALT;
            default:  next_state_s = S_INIT;
        endcase
    end

    // Moore output decode; address fields are only driven in the states that use them.
    always_comb begin
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IM_re      = 1'b0;
        bus.IR_Id      = 1'b0;
        bus.D_addr     = {D_AW{1'b0}};
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = {RF_AW{1'b0}};
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = {RF_AW{1'b0}};
        bus.RF_Rb_addr = {RF_AW{1'b0}};
        bus.ALU_s0     = ALU_PASS;
        bus.Halted     = 1'b0;
        case (state_r)
            S_INIT: begin
                bus.PC_clr = 1'b1;
            end
            S_FETCH: begin
                bus.PC_up = 1'b1;
                bus.IM_re = 1'b1;
                bus.IR_Id = 1'b1;
            end
            S_LOAD_A, S_LOAD_B: begin
                bus.D_addr    = ir_daddr(bus.IR, LD_AD_LSB);
                bus.RF_W_addr = ir_field(bus.IR, RW_LSB);
                bus.RF_s      = 1'b1;
                bus.RF_W_en   = (state_r == S_LOAD_B);
            end
            S_STORE: begin
                bus.D_addr     = ir_daddr(bus.IR, ST_AD_LSB);
                bus.RF_Ra_addr = ir_field(bus.IR, RA_LSB);
                bus.D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = ir_field(bus.IR, RA_LSB);
                bus.RF_Rb_addr = ir_field(bus.IR, RB_LSB);
                bus.RF_W_addr  = ir_field(bus.IR, RW_LSB);
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state_r == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT: begin
                bus.Halted = 1'b1;
            end
            default: begin
                bus.PC_clr = 1'b0;
            end
        endcase
    end

    assign bus.State = state_r;

endmodule

// File: tb/tb_proc_controller.sv
// Self-checking bench for proc_controller: directed instruction table, hand-written
// HALT/reset corner cases and random instruction streams against a cycle-list model.
module tb_proc_controller;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic       im_re;
        logic       ir_id;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halted;
        logic [3:0] state;
    } out_t;

    typedef struct {
        logic [15:0] ir;
        int          cost;
    } vec_t;

    logic Clk;
    logic ResetN;
    int   n_vec;
    int   n_bad;

    proc_controller_if bus();

    proc_controller dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic out_t quiet(input logic [3:0] st);
        out_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic out_t init_out();
        out_t o;
        o = quiet(4'd0);
        o.pc_clr = 1'b1;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.pc_clr = bus.PC_clr;
        o.pc_up  = bus.PC_up;
        o.im_re  = bus.IM_re;
        o.ir_id  = bus.IR_Id;
        o.d_addr = bus.D_addr;
        o.d_wr   = bus.D_wr;
        o.rf_s   = bus.RF_s;
        o.w_addr = bus.RF_W_addr;
        o.w_en   = bus.RF_W_en;
        o.ra     = bus.RF_Ra_addr;
        o.rb     = bus.RF_Rb_addr;
        o.alu    = bus.ALU_s0;
        o.halted = bus.Halted;
        o.state  = bus.State;
        return o;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = sample();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     name, act, act.state, exp, exp.state);
        end
    endtask

    // Reference: expected per-cycle outputs of one instruction, FETCH first.
    function automatic void build_model(input logic [15:0] ir, output out_t q[$]);
        out_t o;
        logic [3:0] op;
        q = {};
        op = ir[15:12];
        o = quiet(4'd1);
        o.pc_up = 1'b1; o.im_re = 1'b1; o.ir_id = 1'b1;
        q.push_back(o);
        q.push_back(quiet(4'd2));
        case (op)
            4'd1: begin
                o = quiet(4'd5);
                o.d_wr = 1'b1; o.d_addr = ir[7:0]; o.ra = ir[11:8];
                q.push_back(o);
            end
            4'd2: begin
                o = quiet(4'd3);
                o.d_addr = ir[11:4]; o.w_addr = ir[3:0]; o.rf_s = 1'b1;
                q.push_back(o);
                o.state = 4'd4; o.w_en = 1'b1;
                q.push_back(o);
            end
            4'd3, 4'd4: begin
                o = quiet((op == 4'd3) ? 4'd6 : 4'd7);
                o.ra = ir[11:8]; o.rb = ir[7:4]; o.w_addr = ir[3:0]; o.w_en = 1'b1;
                o.alu = (op == 4'd3) ? 3'b001 : 3'b010;
                q.push_back(o);
            end
            4'd5: begin
                o = quiet(4'd8);
                o.halted = 1'b1;
                q.push_back(o);
            end
            default: begin
            end
        endcase
    endfunction

    function automatic int cost_of(input logic [3:0] op);
        if (op == 4'd2) return 4;
        if (op == 4'd1 || op == 4'd3 || op == 4'd4) return 3;
        return 2;
    endfunction

    // Entered at a negedge with the DUT expected in FETCH; leaves at the negedge
    // after `cost` cycles, where the DUT must be back in FETCH.
    task automatic run_instr(input string name, input logic [15:0] ir, input int cost);
        out_t q[$];
        out_t fetch_o;
        build_model(ir, q);
        for (int i = 0; i < cost; i++) begin
            if (i < q.size()) check(name, q[i]);
            if (i == 0) bus.IR = ir;
            @(posedge Clk);
            @(negedge Clk);
        end
        fetch_o = quiet(4'd1);
        fetch_o.pc_up = 1'b1; fetch_o.im_re = 1'b1; fetch_o.ir_id = 1'b1;
        check({name, "_cost"}, fetch_o);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_init", init_out());
        ResetN = 1'b1;
        check("init_after_release", init_out());
        @(posedge Clk);
        @(negedge Clk);
    endtask

    vec_t tbl[6];

    initial begin
        out_t q[$];
        logic [15:0] rir;
        int op;

        n_vec  = 0;
        n_bad  = 0;
        ResetN = 1'b0;
        bus.IR = 16'h0000;

        tbl[0] = '{16'h2A35, 4};
        tbl[1] = '{16'h1712, 3};
        tbl[2] = '{16'h3123, 3};
        tbl[3] = '{16'h4123, 3};
        tbl[4] = '{16'hF000, 2};
        tbl[5] = '{16'h0ABC, 2};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_instr($sformatf("tbl%0d_%h", i, tbl[i].ir), tbl[i].ir, tbl[i].cost);
        end

        // HALT holds for 20 cycles, then a reset pulse returns to INIT.
        build_model(16'h5000, q);
        check("halt_fetch", q[0]);
        bus.IR = 16'h5000;
        @(posedge Clk); @(negedge Clk);
        check("halt_decode", q[1]);
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); @(negedge Clk);
            check("halt_hold", q[2]);
        end
        ResetN = 1'b0;
        #1;
        check("halt_reset", init_out());
        bus.IR = 16'h0000;
        @(posedge Clk); @(negedge Clk);
        ResetN = 1'b1;
        check("halt_reset_init", init_out());
        @(posedge Clk); @(negedge Clk);

        // Reset in LOAD_B must kill the RF write without waiting for a clock edge.
        build_model(16'h2A35, q);
        for (int i = 0; i < 4; i++) begin
            check("ldb_seq", q[i]);
            if (i == 0) bus.IR = 16'h2A35;
            if (i < 3) begin
                @(posedge Clk); @(negedge Clk);
            end
        end
        #2;
        ResetN = 1'b0;
        #1;
        check("ldb_reset_abort", init_out());
        @(posedge Clk); @(negedge Clk);
        ResetN = 1'b1;
        @(posedge Clk); @(negedge Clk);

        // Random non-HALT instruction stream against the model.
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 14);
            if (op >= 5) op++;
            rir = {op[3:0], 12'($urandom)};
            run_instr($sformatf("rnd%0d_%h", i, rir), rir, cost_of(op[3:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
